// File: rtl/usb_rx_ctrl_p.sv
// Receive-side USB 1.1 packet controller: PID validation, token capture with
// address filtering, CRC16 stripping via a 2-byte hold, and encoded error status.
module usb_rx_ctrl_p #(
  parameter int         MAX_PKT_BYTES = 64,
  parameter int         BUF_DEPTH     = 64,
  parameter int         OCC_W         = $clog2(BUF_DEPTH + 1),
  parameter int         CNT_W         = $clog2(MAX_PKT_BYTES + 1),
  parameter logic [7:0] SYNC_BYTE     = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             byte_received,
  input  logic [7:0]       rcv_data,
  input  logic             eop,
  input  logic             crc_ok,
  input  logic [OCC_W-1:0] buffer_occupancy,
  input  logic [6:0]       dev_addr,
  output logic             rcving,
  output logic             store_rx_packet_data,
  output logic [7:0]       rx_packet_data,
  output logic             flush,
  output logic             rx_data_ready,
  output logic             r_error,
  output logic [2:0]       err_code,
  output logic [3:0]       pid,
  output logic [6:0]       token_addr,
  output logic [3:0]       token_endp,
  output logic             addr_match,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_TOKEN1, S_TOKEN2, S_TEOP, S_HS, S_DATA, S_EOPW, S_ERR
  } state_t;

  localparam logic [2:0] E_NONE = 3'd0, E_SYNC = 3'd1, E_PID = 3'd2, E_SHORT = 3'd3,
                         E_OVF = 3'd4, E_CRC = 3'd5, E_BYTE = 3'd6;
  localparam logic [3:0] PID_SOF = 4'b0101;

  state_t     state;
  logic [7:0] hold0, hold1;
  logic [1:0] hold_cnt;
  logic       good;
  logic       err_eop_seen;
  logic [2:0] raise_code;
  logic       pid_chk_ok;
  logic       hold_full;
  logic       no_room;

  assign pid_chk_ok = (rcv_data[7:4] == ~rcv_data[3:0]);
  assign hold_full  = (hold_cnt == 2'd2);
  assign no_room    = (byte_count == CNT_W'(MAX_PKT_BYTES)) ||
                      (buffer_occupancy == OCC_W'(BUF_DEPTH));

  function automatic logic pid_supported(input logic [3:0] p);
    case (p)
      4'b0001, 4'b1001, 4'b1101, 4'b0101,
      4'b0011, 4'b1011,
      4'b0010, 4'b1010, 4'b1110: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // A received byte always takes priority; a coincident eop is seen next cycle.
  always_comb begin
    raise_code = E_NONE;
    case (state)
      S_SYNC: begin
        if (byte_received) begin
          if (rcv_data != SYNC_BYTE) raise_code = E_SYNC;
        end else if (eop) raise_code = E_SHORT;
      end
      S_PID: begin
        if (byte_received) begin
          if (!pid_chk_ok || !pid_supported(rcv_data[3:0])) raise_code = E_PID;
        end else if (eop) raise_code = E_SHORT;
      end
      S_TOKEN1, S_TOKEN2: begin
        if (!byte_received && eop) raise_code = E_SHORT;
      end
      S_TEOP: begin
        if (byte_received) raise_code = E_BYTE;
        else if (eop && !crc_ok) raise_code = E_CRC;
      end
      S_HS: begin
        if (byte_received) raise_code = E_BYTE;
      end
      S_DATA: begin
        if (byte_received) begin
          if (hold_full && no_room) raise_code = E_OVF;
        end else if (eop) begin
          if (!hold_full) raise_code = E_SHORT;
          else if (!crc_ok) raise_code = E_CRC;
        end
      end
      default: raise_code = E_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= S_IDLE;
      rcving               <= 1'b0;
      store_rx_packet_data <= 1'b0;
      rx_packet_data       <= 8'h00;
      flush                <= 1'b0;
      rx_data_ready        <= 1'b0;
      r_error              <= 1'b0;
      err_code             <= E_NONE;
      pid                  <= 4'h0;
      token_addr           <= 7'h00;
      token_endp           <= 4'h0;
      addr_match           <= 1'b0;
      byte_count           <= '0;
      hold0                <= 8'h00;
      hold1                <= 8'h00;
      hold_cnt             <= 2'd0;
      good                 <= 1'b0;
      err_eop_seen         <= 1'b0;
    end else begin
      store_rx_packet_data <= 1'b0;
      flush                <= 1'b0;
      rx_data_ready        <= 1'b0;
      if (raise_code != E_NONE) begin
        state        <= S_ERR;
        r_error      <= 1'b1;
        err_code     <= raise_code;
        flush        <= 1'b1;
        err_eop_seen <= eop;
      end else begin
        case (state)
          S_IDLE: begin
            if (d_edge && !eop) begin
              state      <= S_SYNC;
              rcving     <= 1'b1;
              flush      <= 1'b1;
              r_error    <= 1'b0;
              err_code   <= E_NONE;
              byte_count <= '0;
              addr_match <= 1'b0;
              hold_cnt   <= 2'd0;
              good       <= 1'b0;
            end
          end
          S_SYNC: if (byte_received) state <= S_PID;
          S_PID: begin
            if (byte_received) begin
              pid <= rcv_data[3:0];
              case (rcv_data[1:0])
                2'b01:   state <= S_TOKEN1;
                2'b11:   state <= S_DATA;
                default: state <= S_HS;
              endcase
            end
          end
          S_TOKEN1: begin
            if (byte_received) begin
              token_addr    <= rcv_data[6:0];
              token_endp[0] <= rcv_data[7];
              state         <= S_TOKEN2;
            end
          end
          S_TOKEN2: begin
            if (byte_received) begin
              token_endp[3:1] <= rcv_data[2:0];
              addr_match      <= (pid == PID_SOF) ? 1'b1 : (token_addr == dev_addr);
              state           <= S_TEOP;
            end
          end
          S_TEOP: begin
            if (eop) begin
              good  <= addr_match;
              state <= S_EOPW;
            end
          end
          S_HS: begin
            if (eop) begin
              good  <= 1'b1;
              state <= S_EOPW;
            end
          end
          S_DATA: begin
            // The last two bytes held at eop are the CRC16 and are never stored.
            if (byte_received) begin
              if (hold_full) begin
                store_rx_packet_data <= 1'b1;
                rx_packet_data       <= hold0;
                byte_count           <= byte_count + 1'b1;
                hold0                <= hold1;
                hold1                <= rcv_data;
              end else if (hold_cnt == 2'd0) begin
                hold0    <= rcv_data;
                hold_cnt <= 2'd1;
              end else begin
                hold1    <= rcv_data;
                hold_cnt <= 2'd2;
              end
            end else if (eop) begin
              hold_cnt <= 2'd0;
              good     <= 1'b1;
              state    <= S_EOPW;
            end
          end
          S_EOPW: begin
            if (!eop) begin
              rx_data_ready <= good;
              rcving        <= 1'b0;
              state         <= S_IDLE;
            end
          end
          S_ERR: begin
            if (eop) err_eop_seen <= 1'b1;
            else if (err_eop_seen) begin
              rcving <= 1'b0;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl_p.sv
// Directed bench for usb_rx_ctrl_p: token, handshake, data and error packets.
module tb_usb_rx_ctrl_p;

  localparam int OCC_W = 7;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             d_edge = 1'b0;
  logic             byte_received = 1'b0;
  logic [7:0]       rcv_data = 8'h00;
  logic             eop = 1'b0;
  logic             crc_ok = 1'b0;
  logic [OCC_W-1:0] buffer_occupancy = '0;
  logic [6:0]       dev_addr = 7'h05;
  logic             rcving, store_rx_packet_data, flush, rx_data_ready, r_error, addr_match;
  logic [7:0]       rx_packet_data;
  logic [2:0]       err_code;
  logic [3:0]       pid, token_endp;
  logic [6:0]       token_addr;
  logic [CNT_W-1:0] byte_count;

  usb_rx_ctrl_p dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .byte_received(byte_received),
    .rcv_data(rcv_data), .eop(eop), .crc_ok(crc_ok),
    .buffer_occupancy(buffer_occupancy), .dev_addr(dev_addr),
    .rcving(rcving), .store_rx_packet_data(store_rx_packet_data),
    .rx_packet_data(rx_packet_data), .flush(flush), .rx_data_ready(rx_data_ready),
    .r_error(r_error), .err_code(err_code), .pid(pid), .token_addr(token_addr),
    .token_endp(token_endp), .addr_match(addr_match), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int store_cnt = 0, flush_cnt = 0, rdy_cnt = 0;
  logic [7:0] store_log [0:511];
  int st0, fl0, rd0;

  always @(negedge clk) begin
    if (store_rx_packet_data) begin
      if (store_cnt < 512) store_log[store_cnt] = rx_packet_data;
      store_cnt++;
    end
    if (flush) flush_cnt++;
    if (rx_data_ready) rdy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    st0 = store_cnt; fl0 = flush_cnt; rd0 = rdy_cnt;
  endtask

  task automatic start_pkt();
    @(negedge clk); d_edge = 1'b1;
    @(negedge clk); d_edge = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); byte_received = 1'b1; rcv_data = b;
    @(negedge clk); byte_received = 1'b0;
  endtask

  task automatic finish_pkt(input logic good_crc);
    @(negedge clk); eop = 1'b1; crc_ok = good_crc;
    repeat (2) @(negedge clk);
    eop = 1'b0; crc_ok = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rcving", rcving, 0);
    chk("rst_store", store_rx_packet_data, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ready", rx_data_ready, 0);
    chk("rst_rerror", r_error, 0);
    chk("rst_errcode", err_code, 0);
    chk("rst_pid", pid, 0);
    chk("rst_bytecount", byte_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // OUT token to our address
    mark();
    start_pkt();
    chk("tok_rcving", rcving, 1);
    send_byte(8'h01); send_byte(8'hE1); send_byte(8'h05); send_byte(8'h00);
    finish_pkt(1'b1);
    $display("[TB] token addr 05 dev 05: pid=%0h addr=%0h endp=%0h match=%0b", pid, token_addr, token_endp, addr_match);
    chk("tok_pid", pid, 4'h1);
    chk("tok_addr", token_addr, 7'h05);
    chk("tok_endp", token_endp, 4'h0);
    chk("tok_match", addr_match, 1);
    chk("tok_ready", rdy_cnt - rd0, 1);
    chk("tok_stores", store_cnt - st0, 0);
    chk("tok_flush", flush_cnt - fl0, 1);
    chk("tok_idle", rcving, 0);

    // Same token, other device
    dev_addr = 7'h06;
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hE1); send_byte(8'h05); send_byte(8'h00);
    finish_pkt(1'b1);
    $display("[TB] token addr 05 dev 06: match=%0b r_error=%0b", addr_match, r_error);
    chk("mis_match", addr_match, 0);
    chk("mis_ready", rdy_cnt - rd0, 0);
    chk("mis_rerror", r_error, 0);
    dev_addr = 7'h05;

    // IN token with nonzero endpoint bits spanning both bytes
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'h69); send_byte(8'h85); send_byte(8'h03);
    finish_pkt(1'b1);
    $display("[TB] IN token: pid=%0h endp=%0h", pid, token_endp);
    chk("in_pid", pid, 4'h9);
    chk("in_endp", token_endp, 4'h7);
    chk("in_ready", rdy_cnt - rd0, 1);

    // DATA0 with 3 payload bytes
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hC3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hC1); send_byte(8'hC2);
    finish_pkt(1'b1);
    $display("[TB] DATA0 3 bytes: stores=%0d byte_count=%0d", store_cnt - st0, byte_count);
    chk("d3_stores", store_cnt - st0, 3);
    chk("d3_b0", store_log[st0], 8'hAA);
    chk("d3_b1", store_log[st0 + 1], 8'hBB);
    chk("d3_b2", store_log[st0 + 2], 8'hCC);
    chk("d3_count", byte_count, 3);
    chk("d3_ready", rdy_cnt - rd0, 1);
    chk("d3_pid", pid, 4'h3);

    // Zero-length DATA1
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'h4B); send_byte(8'hC1); send_byte(8'hC2);
    finish_pkt(1'b1);
    $display("[TB] DATA1 zero length: stores=%0d byte_count=%0d", store_cnt - st0, byte_count);
    chk("zl_count", byte_count, 0);
    chk("zl_stores", store_cnt - st0, 0);
    chk("zl_ready", rdy_cnt - rd0, 1);

    // Overflow: 66 payload bytes
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hC3);
    for (int i = 0; i < 66; i++) send_byte(8'(i));
    send_byte(8'hC1); send_byte(8'hC2);
    $display("[TB] DATA0 66 bytes: stores=%0d err=%0d", store_cnt - st0, err_code);
    chk("ovf_stores", store_cnt - st0, 64);
    chk("ovf_last", store_log[st0 + 63], 8'h3F);
    chk("ovf_rerror", r_error, 1);
    chk("ovf_code", err_code, 4);
    chk("ovf_flush", flush_cnt - fl0, 2);
    chk("ovf_busy", rcving, 1);
    finish_pkt(1'b1);
    chk("ovf_ready", rdy_cnt - rd0, 0);
    chk("ovf_idle", rcving, 0);

    // Bad PID check nibble
    start_pkt();
    chk("pid_clr", r_error, 0);
    send_byte(8'h01); send_byte(8'hC4);
    finish_pkt(1'b1);
    $display("[TB] PID C4: err=%0d", err_code);
    chk("pid_code", err_code, 2);

    // Bad sync
    start_pkt();
    send_byte(8'h03);
    finish_pkt(1'b1);
    $display("[TB] sync 03: err=%0d", err_code);
    chk("sync_code", err_code, 1);
    chk("sync_rerror", r_error, 1);

    // Good ACK
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hD2);
    finish_pkt(1'b1);
    $display("[TB] ACK: pid=%0h ready=%0d", pid, rdy_cnt - rd0);
    chk("ack_pid", pid, 4'h2);
    chk("ack_ready", rdy_cnt - rd0, 1);

    // ACK plus extra byte
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hD2); send_byte(8'h55);
    finish_pkt(1'b1);
    $display("[TB] ACK+byte: err=%0d", err_code);
    chk("ackx_code", err_code, 6);
    chk("ackx_ready", rdy_cnt - rd0, 0);

    // DATA with CRC failure
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hC3); send_byte(8'h11); send_byte(8'hC1); send_byte(8'hC2);
    finish_pkt(1'b0);
    $display("[TB] DATA crc bad: err=%0d", err_code);
    chk("crc_code", err_code, 5);
    chk("crc_ready", rdy_cnt - rd0, 0);

    // Early EOP in DATA with hold not full
    start_pkt();
    send_byte(8'h01); send_byte(8'hC3); send_byte(8'hAA);
    finish_pkt(1'b1);
    $display("[TB] DATA short: err=%0d", err_code);
    chk("short_code", err_code, 3);

    // Reset mid-DATA
    start_pkt();
    send_byte(8'h01); send_byte(8'hC3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    @(negedge clk); rst = 1'b1; #1;
    $display("[TB] mid-data reset: rcving=%0b count=%0d pid=%0h", rcving, byte_count, pid);
    chk("mrst_rcving", rcving, 0);
    chk("mrst_count", byte_count, 0);
    chk("mrst_data", rx_packet_data, 0);
    chk("mrst_pid", pid, 0);
    @(negedge clk); rst = 1'b0;
    finish_pkt(1'b1);
    chk("mrst_idle", rcving, 0);
    mark();
    start_pkt();
    send_byte(8'h01); send_byte(8'hC3);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    finish_pkt(1'b1);
    $display("[TB] post-reset DATA: stores=%0d count=%0d", store_cnt - st0, byte_count);
    chk("post_stores", store_cnt - st0, 2);
    chk("post_b0", store_log[st0], 8'h11);
    chk("post_b1", store_log[st0 + 1], 8'h22);
    chk("post_ready", rdy_cnt - rd0, 1);
    chk("post_rerror", r_error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_rx_ctrl_p.md
Name: usb_rx_ctrl_p

Overview:
Parametrised receive-side packet controller for the USB 1.1 device core, the next generation of the receiver control unit. Sits between the bit-level decoder/shift register (d_edge, byte_received, rcv_data, eop) and the RX data buffer. Adds the following over the previous unit:
- full PID check-nibble validation and 4-bit PID reporting
- token field capture with device-address filtering
- CRC16 stripping through a 2-byte hold pipeline
- configurable payload and buffer limits
- encoded error status

Parameters:
MAX_PKT_BYTES, 64, maximum DATA payload bytes accepted, CRC excluded.
BUF_DEPTH, 64, RX buffer capacity in bytes.
OCC_W, $clog2(BUF_DEPTH+1), width of buffer_occupancy (derived).
CNT_W, $clog2(MAX_PKT_BYTES+1), width of byte_count (derived).
SYNC_BYTE, 8'h01, expected sync byte as presented by the shift register.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
d_edge  in  1  line transition detected (packet start)
byte_received  in  1  1-cycle pulse; rcv_data valid this cycle
rcv_data  in  8  received byte
eop  in  1  level, SE0 present on line
crc_ok  in  1  external CRC5/CRC16 checker result, valid while eop=1
buffer_occupancy  in  OCC_W  current RX buffer fill
dev_addr  in  7  assigned device address
rcving  out  1  packet in progress
store_rx_packet_data  out  1  1-cycle write strobe to buffer
rx_packet_data  out  8  byte written with store strobe
flush  out  1  1-cycle buffer flush
rx_data_ready  out  1  1-cycle good-packet pulse
r_error  out  1  sticky error, cleared at next packet start
err_code  out  3  0 none, 1 bad sync, 2 PID check fail, 3 short/early EOP, 4 overflow, 5 CRC fail, 6 unexpected byte
pid  out  4  validated PID nibble
token_addr  out  7  token address, or SOF frame[6:0]
token_endp  out  4  token endpoint, or SOF frame[10:7]
addr_match  out  1  token_addr==dev_addr, valid after TOKEN2
byte_count  out  CNT_W  payload bytes stored this packet

Behaviour:
- Reset: all outputs 0; state IDLE; hold pipeline empty. A reset mid-packet abandons it immediately. The next d_edge gives SYNC, which normally ends in bad-sync error 1, then drains to EOP.
- States:
  - IDLE: rcving=0. On d_edge with eop=0: go to SYNC; flush pulse; clear r_error, err_code, byte_count, addr_match, hold.
  - SYNC: on byte_received, rcv_data==SYNC_BYTE goes to PID, otherwise error 1. eop goes to error 3.
  - PID: on byte_received, error 2 if rcv_data[7:4] != ~rcv_data[3:0]. Otherwise pid <= rcv_data[3:0], then branch:
    - OUT/IN/SETUP/SOF (0001/1001/1101/0101) go to TOKEN1.
    - DATA0/DATA1 (0011/1011) go to DATA.
    - ACK/NAK/STALL (0010/1010/1110) go to HS.
    - Any other valid PID gives error 2.
    - eop goes to error 3.
  - TOKEN1: byte sets token_addr=b[6:0], token_endp[0]=b[7], then TOKEN2. eop gives error 3.
  - TOKEN2: byte sets token_endp[3:1]=b[2:0], then TEOP. For non-SOF, addr_match <= token_addr==dev_addr; SOF forces addr_match=1. eop gives error 3.
  - TEOP: eop with crc_ok goes to EOPW, good = addr_match. eop with !crc_ok gives error 5. byte gives error 6.
  - HS: eop goes to EOPW with good=1. byte gives error 6.
  - DATA: 2-entry hold FIFO. Each byte_received with hold full first pops the oldest byte:
    - The pop raises error 4 if byte_count==MAX_PKT_BYTES or buffer_occupancy==BUF_DEPTH.
    - Otherwise the popped byte drives rx_packet_data and store_rx_packet_data on the next cycle, and byte_count increments.
    - The new byte is then pushed.
    - On eop: hold not full gives error 3. !crc_ok gives error 5. Otherwise discard hold (CRC16), go to EOPW, good=1.
  - EOPW: wait for eop=0, then IDLE. On that transition, rx_data_ready pulses if good.
  - ERR: entry sets r_error=1, latches err_code, and pulses flush once. Wait for eop=1 then eop=0, then IDLE. rcving stays 1 until IDLE.
- Simultaneous byte_received and eop: the byte is processed first, then eop is evaluated the next cycle.
- Address mismatch is not an error: no rx_data_ready, r_error=0.
- Zero-length DATA packet (exactly 2 bytes, CRC only) is good with byte_count=0.

Test Plan:
- dev_addr=7'h05; bytes 01,E1,05,00 (crc_ok=1), eop -> pid=4'h1, token_addr=05, token_endp=0, addr_match=1, one rx_data_ready pulse, no store.
- Same packet with dev_addr=7'h06 -> addr_match=0, no rx_data_ready, r_error=0.
- 01,C3,AA,BB,CC,C1,C2, eop, crc_ok=1 -> exactly 3 stores (AA,BB,CC), byte_count=3, rx_data_ready pulse.
- DATA0 with 66 payload bytes plus CRC, MAX_PKT_BYTES=64 -> 64 stores, then r_error=1, err_code=4, flush pulse. No rx_data_ready; IDLE after EOP.
- PID byte 0xC4 -> err_code=2. Sync byte 0x03 -> err_code=1. ACK followed by extra byte -> err_code=6.
- rst asserted mid-DATA -> all outputs 0 within the same cycle; next clean packet after eop is received correctly.
